// File: rtl/id_hazard_if.sv
// Decode-stage hazard bus: fetch/decode/EX inputs and the IF/ID plus pipeline-control outputs.
`default_nettype none

interface id_hazard_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      if_instr;
  logic [31:0]      if_pc;
  logic             if_valid;
  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             ex_md_start;
  logic             md_done;
  logic [31:0]      id_instr;
  logic [31:0]      id_pc;
  logic             id_flush;
  logic             pc_stall;
  logic             ex_bubble;
  logic             ex_hold;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  if_instr, if_pc, if_valid, id_opcode, id_rs1, id_rs2,
           ex_mem_read, ex_rd, ex_redirect, ex_md_start, md_done,
    output id_instr, id_pc, id_flush, pc_stall, ex_bubble, ex_hold,
           md_timeout, stall_cnt
  );

  modport master (
    output if_instr, if_pc, if_valid, id_opcode, id_rs1, id_rs2,
           ex_mem_read, ex_rd, ex_redirect, ex_md_start, md_done,
    input  id_instr, id_pc, id_flush, pc_stall, ex_bubble, ex_hold,
           md_timeout, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
// RV32I decode-stage hazard controller: IF/ID register, load-use, redirect and mul/div stalls.
// Mul/div wait state and watchdog are built only when ID_HAZARD_MULDIV_EN is defined.
`default_nettype none

module id_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  id_hazard_if.slave bus
);
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [31:0]      id_instr_q;
  logic [31:0]      id_pc_q;
  logic             id_valid;
  logic [CNT_W-1:0] stall_cnt_q;

  logic uses_rs1;
  logic uses_rs2;
  logic lu_hazard;
  logic in_md;
  logic md_busy;
  logic md_start;
  logic stall_c;
  logic bubble_c;
  logic hold_c;
  logic id_load;
  logic id_squash;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (bus.id_opcode)
      OP_REG, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign lu_hazard = id_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                     ((uses_rs1 & (bus.ex_rd == bus.id_rs1)) |
                      (uses_rs2 & (bus.ex_rd == bus.id_rs2)));

`ifdef ID_HAZARD_MULDIV_EN
  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  localparam int WD_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

  state_t          state;
  logic [WD_W-1:0] wd_cnt;
  logic            md_to;
  logic            wd_hit;

  assign in_md    = (state == ST_MD_WAIT);
  assign md_busy  = in_md & ~bus.md_done;
  // A redirect in the same cycle kills the mul/div op before it can occupy EX.
  assign md_start = ~in_md & ~bus.ex_redirect & bus.ex_md_start;
  assign wd_hit   = (wd_cnt == WD_W'(MD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      wd_cnt <= '0;
      md_to  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (md_start) begin
            state  <= ST_MD_WAIT;
            wd_cnt <= '0;
          end
        end
        ST_MD_WAIT: begin
          if (bus.md_done) begin
            state <= ST_RUN;
          end else if (wd_hit) begin
            md_to <= 1'b1;
            state <= ST_RUN;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.md_timeout = md_to;
`else
  localparam int unused_md_timeout = MD_TIMEOUT;
  logic unused_md;

  assign unused_md      = bus.ex_md_start ^ bus.md_done;
  assign in_md          = 1'b0;
  assign md_busy        = 1'b0;
  assign md_start       = 1'b0;
  assign bus.md_timeout = 1'b0;
`endif

  always_comb begin
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    hold_c    = 1'b0;
    id_load   = 1'b0;
    id_squash = 1'b0;
    if (in_md) begin
      if (md_busy) begin
        stall_c = 1'b1;
        hold_c  = 1'b1;
      end else begin
        id_load = 1'b1;
      end
    end else if (bus.ex_redirect) begin
      bubble_c  = 1'b1;
      id_squash = 1'b1;
    end else if (md_start) begin
      id_load = 1'b1;
    end else if (lu_hazard) begin
      stall_c  = 1'b1;
      bubble_c = 1'b1;
    end else begin
      id_load = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instr_q  <= 32'd0;
      id_pc_q     <= 32'd0;
      id_valid    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (id_squash) begin
        id_instr_q <= 32'd0;
        id_valid   <= 1'b0;
      end else if (id_load) begin
        id_instr_q <= bus.if_instr;
        id_pc_q    <= bus.if_pc;
        id_valid   <= bus.if_valid;
      end
      if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  // Controls are held low while reset is asserted, regardless of inputs.
  assign bus.pc_stall  = stall_c & rst_n;
  assign bus.ex_bubble = bubble_c & rst_n;
  assign bus.ex_hold   = hold_c & rst_n;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_flush  = ~id_valid;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: directed stimulus queues expectations, a negedge monitor checks them.
`default_nettype none

module tb_id_hazard_ctrl;
  logic clk;
  logic rst_n;
  int   cyc;
  int   n_run;
  int   n_fail;

  id_hazard_if #(.CNT_W(16)) bus ();

  id_hazard_ctrl #(
    .MD_TIMEOUT(8),
    .CNT_W     (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] instr;
    logic        flush;
    logic        stall;
    logic        bubble;
    logic        hold;
    logic        mto;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t e;

  localparam logic [31:0] I_A = 32'h00500093;
  localparam logic [31:0] I_B = 32'h002081B3;
  localparam logic [31:0] I_N = 32'h00000013;
  localparam logic [31:0] I_C = 32'h00C00113;
  localparam logic [31:0] I_D = 32'h00000537;
  localparam logic [31:0] I_E = 32'h00100193;
  localparam logic [31:0] I_F = 32'h00208233;
  localparam logic [31:0] I_G = 32'h02208233;
  localparam logic [31:0] I_H = 32'h00000013;
  localparam logic [31:0] I_I = 32'h00000093;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation whose cycle has come and compares all observed outputs.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_run++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: sample missed, due cycle %0d, now %0d", e.name, e.cyc, cyc);
      end else if ({bus.id_instr, bus.id_flush, bus.pc_stall, bus.ex_bubble, bus.ex_hold,
                    bus.md_timeout, bus.stall_cnt} !==
                   {e.instr, e.flush, e.stall, e.bubble, e.hold, e.mto, e.cnt}) begin
        n_fail++;
        $display("FAIL %s: got instr=%h flush=%b stall=%b bubble=%b hold=%b mto=%b cnt=%0d, want instr=%h flush=%b stall=%b bubble=%b hold=%b mto=%b cnt=%0d",
                 e.name, bus.id_instr, bus.id_flush, bus.pc_stall, bus.ex_bubble, bus.ex_hold,
                 bus.md_timeout, bus.stall_cnt, e.instr, e.flush, e.stall, e.bubble, e.hold,
                 e.mto, e.cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] instr, input logic flush,
                     input logic stall, input logic bubble, input logic hold,
                     input logic mto, input logic [15:0] cnt);
    exp_t x;
    x.name   = n;
    x.cyc    = cyc;
    x.instr  = instr;
    x.flush  = flush;
    x.stall  = stall;
    x.bubble = bubble;
    x.hold   = hold;
    x.mto    = mto;
    x.cnt    = cnt;
    q.push_back(x);
  endtask

  task automatic id_decode(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2);
    bus.id_opcode = op;
    bus.id_rs1    = rs1;
    bus.id_rs2    = rs2;
  endtask

  initial begin
    cyc    = 0;
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.if_instr    = I_A;
    bus.if_pc       = 32'h100;
    bus.if_valid    = 1'b1;
    bus.ex_mem_read = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.ex_redirect = 1'b0;
    bus.ex_md_start = 1'b0;
    bus.md_done     = 1'b0;
    id_decode(7'b0010011, 5'd0, 5'd5);
    #1;
    chk("reset", 32'd0, 1, 0, 0, 0, 0, 16'd0);
    #5 rst_n = 1'b1;

    step();  // C1
    bus.if_instr = I_B;
    bus.if_pc    = 32'h104;
    chk("capture", I_A, 0, 0, 0, 0, 0, 16'd0);

    step();  // C2: add x3,x1,x2 in ID, load to x2 in EX
    bus.if_instr = I_N;
    id_decode(7'b0110011, 5'd1, 5'd2);
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd2;
    chk("lu_rs2", I_B, 0, 1, 1, 0, 0, 16'd0);

    step();  // C3
    bus.ex_mem_read = 1'b0;
    bus.ex_rd       = 5'd0;
    chk("lu_clear", I_B, 0, 0, 0, 0, 0, 16'd1);

    step();  // C4
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd0;
    bus.if_instr    = I_C;
    chk("lu_rd0", I_N, 0, 0, 0, 0, 0, 16'd1);

    step();  // C5
    bus.ex_rd = 5'd1;
    chk("lu_rs1", I_C, 0, 1, 1, 0, 0, 16'd1);

    step();  // C6: LUI reads no registers
    id_decode(7'b0110111, 5'd1, 5'd1);
    bus.if_instr = I_D;
    chk("lui_nohz", I_C, 0, 0, 0, 0, 0, 16'd2);

    step();  // C7: redirect with a simultaneous load-use hazard
    id_decode(7'b0110011, 5'd1, 5'd2);
    bus.ex_redirect = 1'b1;
    bus.if_instr    = I_E;
    chk("redirect", I_D, 0, 0, 1, 0, 0, 16'd2);

    step();  // C8
    bus.ex_redirect = 1'b0;
    bus.ex_mem_read = 1'b0;
    chk("post_redir", 32'd0, 1, 0, 0, 0, 0, 16'd2);

    step();  // C9
    bus.if_valid = 1'b0;
    chk("refetch", I_E, 0, 0, 0, 0, 0, 16'd2);

    step();  // C10
    bus.if_valid = 1'b1;
    bus.if_instr = I_F;
    chk("fetch_inval", I_E, 1, 0, 0, 0, 0, 16'd2);

    step();  // C11
    bus.ex_md_start = 1'b1;
    bus.if_instr    = I_G;
    chk("md_start", I_F, 0, 0, 0, 0, 0, 16'd2);

`ifdef ID_HAZARD_MULDIV_EN
    step();  // C12: MD_WAIT cycle 1
    bus.ex_md_start = 1'b0;
    chk("md_w1", I_G, 0, 1, 0, 1, 0, 16'd2);
    step();  // C13
    bus.ex_redirect = 1'b1;
    chk("md_w2_redir", I_G, 0, 1, 0, 1, 0, 16'd3);
    step();  // C14
    bus.ex_redirect = 1'b0;
    chk("md_w3", I_G, 0, 1, 0, 1, 0, 16'd4);
    step();  // C15
    chk("md_w4", I_G, 0, 1, 0, 1, 0, 16'd5);
    step();  // C16
    chk("md_w5", I_G, 0, 1, 0, 1, 0, 16'd6);
    step();  // C17
    bus.md_done  = 1'b1;
    bus.if_instr = I_H;
    chk("md_done", I_G, 0, 0, 0, 0, 0, 16'd7);
    step();  // C18
    bus.md_done     = 1'b0;
    bus.ex_md_start = 1'b1;
    bus.if_instr    = I_I;
    chk("md_run", I_H, 0, 0, 0, 0, 0, 16'd7);
    step();  // C19: watchdog run, MD_WAIT cycle 1
    bus.ex_md_start = 1'b0;
    chk("to_w1", I_I, 0, 1, 0, 1, 0, 16'd7);
    for (int k = 0; k < 7; k++) step();  // C26: MD_WAIT cycle 8
    chk("to_w8", I_I, 0, 1, 0, 1, 0, 16'd14);
    step();  // C27
    chk("to_set", I_I, 0, 0, 0, 0, 1, 16'd15);
    step();  // C28
    chk("to_sticky", I_I, 0, 0, 0, 0, 1, 16'd15);
    step();  // C29
    bus.ex_md_start = 1'b1;
    step();  // C30
    bus.ex_md_start = 1'b0;
    step();  // C31: reset mid-wait
    rst_n = 1'b0;
    chk("md_async_rst", 32'd0, 1, 0, 0, 0, 0, 16'd0);
    step();  // C32
    rst_n = 1'b1;
    chk("md_post_rst", 32'd0, 1, 0, 0, 0, 0, 16'd0);
    step();  // C33
    chk("md_resume", I_I, 0, 0, 0, 0, 0, 16'd0);
`else
    step();  // C12
    bus.ex_md_start = 1'b0;
    bus.md_done     = 1'b1;
    chk("md_ignored", I_G, 0, 0, 0, 0, 0, 16'd2);
    step();  // C13
    bus.md_done     = 1'b0;
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd1;
    chk("lu_pre_rst", I_G, 0, 1, 1, 0, 0, 16'd2);
    step();  // C14: reset mid-stall with the hazard still present
    rst_n = 1'b0;
    chk("stall_async_rst", 32'd0, 1, 0, 0, 0, 0, 16'd0);
    step();  // C15
    rst_n = 1'b1;
    bus.ex_mem_read = 1'b0;
    chk("post_rst", 32'd0, 1, 0, 0, 0, 0, 16'd0);
    step();  // C16
    chk("resume", I_G, 0, 0, 0, 0, 0, 16'd0);
`endif

    for (int k = 0; k < 10 && q.size() > 0; k++) step();
    if (q.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
